// File: rtl/lease_table_loader_pkg.sv
// Shared definitions for the lease table loader.
//   - Loader FSM state encoding
//   - Probability field width
//   - CLOG2 helper macro
//   - Array-select values for the table address MSB
`ifndef LEASE_TABLE_LOADER_CLOG2
`define LEASE_TABLE_LOADER_CLOG2
`define CLOG2(x) $clog2(x)
`endif

package lease_table_loader_pkg;

  localparam int PROB_W = 9;

  // The table address MSB picks the array.
  // Array 0 holds ref addr/lease0; array 1 holds lease1/prob.
  localparam logic ARR_SEL_LEASE0 = 1'b0;
  localparam logic ARR_SEL_LEASE1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_T1 = 2'd1,
    ST_WR_T0 = 2'd2,
    ST_CLEAR = 2'd3
  } ltl_state_e;

endpackage

// File: rtl/lease_table_loader.sv
// Lease table loader: converts one lease record per valid/ready handshake into
// the table's two-array write sequence. It also owns the table write pointer,
// the fill count and sticky overflow status, and sweeps the table on clear.
//
// Ports:
//   clock_i, reset_i       clock, synchronous active-high reset
//   rec_*                  record input handshake and fields
//   clear_i                pulse: invalidate the whole table, reset pointer
//   busy_o                 FSM not idle
//   count_o, full_o        entries written since clear/reset, count == N_ENTRIES
//   overflow_o             sticky: a record arrived while full and was dropped
//   tbl_*                  table write/invalidate port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a record or clear; drives {0,ptr} on tbl_addr_o
// ST_WR_T1 | writes lease1/prob into array 1 at ptr
// ST_WR_T0 | writes ref addr/lease0 into array 0 at ptr (marks entry valid)
// ST_CLEAR | invalidates array-0 entries 0..N_ENTRIES-1, one per cycle
module lease_table_loader
  import lease_table_loader_pkg::*;
#(
  parameter int unsigned N_ENTRIES         = 128,
  parameter int unsigned BW_LEASE_REGISTER = 32,
  parameter int unsigned BW_REF_ADDR       = 32,
  localparam int unsigned BW_ENTRIES       = `CLOG2(N_ENTRIES)
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         rec_valid_i,
  output logic                         rec_ready_o,
  input  logic [BW_REF_ADDR-1:0]       rec_ref_addr_i,
  input  logic [BW_LEASE_REGISTER-1:0] rec_lease0_i,
  input  logic [BW_LEASE_REGISTER-1:0] rec_lease1_i,
  input  logic [PROB_W-1:0]            rec_prob_i,
  input  logic                         clear_i,
  output logic                         busy_o,
  output logic [BW_ENTRIES:0]          count_o,
  output logic                         full_o,
  output logic                         overflow_o,
  output logic [BW_ENTRIES:0]          tbl_addr_o,
  output logic                         tbl_wren_ref_addr_o,
  output logic                         tbl_wren_lease_o,
  output logic                         tbl_rmen_o,
  output logic [BW_REF_ADDR-1:0]       tbl_ref_addr_o,
  output logic [BW_LEASE_REGISTER-1:0] tbl_lease_o
);

  localparam int unsigned BW_CNT = BW_ENTRIES + 1;
  localparam logic [BW_CNT-1:0] COUNT_FULL = BW_CNT'(N_ENTRIES);

  ltl_state_e                   state_q, state_d;
  logic [BW_ENTRIES-1:0]        ptr_q, ptr_d;
  logic [BW_CNT-1:0]            count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic                         clear_pending_q, clear_pending_d;
  logic [BW_ENTRIES-1:0]        clr_cnt_q, clr_cnt_d;
  logic [BW_REF_ADDR-1:0]       ref_addr_q, ref_addr_d;
  logic [BW_LEASE_REGISTER-1:0] lease0_q, lease0_d;
  logic [BW_LEASE_REGISTER-1:0] lease1_q, lease1_d;
  logic [PROB_W-1:0]            prob_q, prob_d;
  logic                         full;
  logic                         rec_ready;

  assign full = (count_q == COUNT_FULL);

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    count_d             = count_q;
    overflow_d          = overflow_q;
    clear_pending_d     = clear_pending_q;
    clr_cnt_d           = clr_cnt_q;
    ref_addr_d          = ref_addr_q;
    lease0_d            = lease0_q;
    lease1_d            = lease1_q;
    prob_d              = prob_q;
    rec_ready           = 1'b0;
    tbl_addr_o          = {ARR_SEL_LEASE0, ptr_q};
    tbl_wren_ref_addr_o = 1'b0;
    tbl_wren_lease_o    = 1'b0;
    tbl_rmen_o          = 1'b0;
    tbl_ref_addr_o      = '0;
    tbl_lease_o         = '0;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so nothing looks accepted while reset is held.
        rec_ready = !clear_i && !clear_pending_q && !reset_i;
        if (clear_i || clear_pending_q) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '1;
        end else if (rec_valid_i && rec_ready) begin
          ref_addr_d = rec_ref_addr_i;
          lease0_d   = rec_lease0_i;
          lease1_d   = rec_lease1_i;
          prob_d     = rec_prob_i;
          // When full the record is swallowed so upstream never stalls.
          if (full) overflow_d = 1'b1;
          else      state_d    = ST_WR_T1;
        end
      end

      ST_WR_T1: begin
        tbl_addr_o          = {ARR_SEL_LEASE1, ptr_q};
        tbl_wren_ref_addr_o = 1'b1;
        tbl_wren_lease_o    = 1'b1;
        tbl_ref_addr_o      = BW_REF_ADDR'(lease1_q);
        tbl_lease_o         = BW_LEASE_REGISTER'(prob_q);
        if (clear_i) clear_pending_d = 1'b1;
        state_d = ST_WR_T0;
      end

      ST_WR_T0: begin
        tbl_addr_o          = {ARR_SEL_LEASE0, ptr_q};
        tbl_wren_ref_addr_o = 1'b1;
        tbl_wren_lease_o    = 1'b1;
        tbl_ref_addr_o      = ref_addr_q;
        tbl_lease_o         = lease0_q;
        ptr_d               = ptr_q + 1'b1;
        count_d             = count_q + 1'b1;
        if (clear_i || clear_pending_q) begin
          clear_pending_d = 1'b1;
          clr_cnt_d       = '1;
          state_d         = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        // Remaining-count down-counter; N is a power of two, so the
        // ascending index is just its bitwise inverse.
        tbl_addr_o = {ARR_SEL_LEASE0, ~clr_cnt_q};
        tbl_rmen_o = 1'b1;
        if (clr_cnt_q == '0) begin
          ptr_d           = '0;
          count_d         = '0;
          overflow_d      = 1'b0;
          clear_pending_d = 1'b0;
          state_d         = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
      ref_addr_q      <= '0;
      lease0_q        <= '0;
      lease1_q        <= '0;
      prob_q          <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
      clear_pending_q <= clear_pending_d;
      clr_cnt_q       <= clr_cnt_d;
      ref_addr_q      <= ref_addr_d;
      lease0_q        <= lease0_d;
      lease1_q        <= lease1_d;
      prob_q          <= prob_d;
    end
  end

  assign rec_ready_o = rec_ready;
  assign busy_o      = (state_q != ST_IDLE);
  assign count_o     = count_q;
  assign full_o      = full;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_lease_table_loader.sv
// Directed bench for lease_table_loader with a 4-entry table.
module tb_lease_table_loader;

  localparam int N   = 4;
  localparam int BWR = 32;
  localparam int BWL = 32;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           rec_valid_i = 1'b0;
  logic           rec_ready_o;
  logic [BWR-1:0] rec_ref_addr_i = '0;
  logic [BWL-1:0] rec_lease0_i = '0;
  logic [BWL-1:0] rec_lease1_i = '0;
  logic [8:0]     rec_prob_i = '0;
  logic           clear_i = 1'b0;
  logic           busy_o;
  logic [2:0]     count_o;
  logic           full_o;
  logic           overflow_o;
  logic [2:0]     tbl_addr_o;
  logic           tbl_wren_ref_addr_o;
  logic           tbl_wren_lease_o;
  logic           tbl_rmen_o;
  logic [BWR-1:0] tbl_ref_addr_o;
  logic [BWL-1:0] tbl_lease_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_i = ~clock_i;

  lease_table_loader #(
    .N_ENTRIES(N), .BW_LEASE_REGISTER(BWL), .BW_REF_ADDR(BWR)
  ) u_dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_o),
    .rec_ref_addr_i(rec_ref_addr_i), .rec_lease0_i(rec_lease0_i),
    .rec_lease1_i(rec_lease1_i), .rec_prob_i(rec_prob_i),
    .clear_i(clear_i), .busy_o(busy_o), .count_o(count_o),
    .full_o(full_o), .overflow_o(overflow_o), .tbl_addr_o(tbl_addr_o),
    .tbl_wren_ref_addr_o(tbl_wren_ref_addr_o), .tbl_wren_lease_o(tbl_wren_lease_o),
    .tbl_rmen_o(tbl_rmen_o), .tbl_ref_addr_o(tbl_ref_addr_o), .tbl_lease_o(tbl_lease_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  // Offer a record, confirm ready, let it be taken; returns in WR_T1 cycle.
  task automatic offer(input string tag, input logic [31:0] ra, input logic [31:0] l0,
                       input logic [31:0] l1, input logic [8:0] p);
    rec_ref_addr_i = ra;
    rec_lease0_i   = l0;
    rec_lease1_i   = l1;
    rec_prob_i     = p;
    rec_valid_i    = 1'b1;
    #1;
    check_eq({tag, "_ready"}, rec_ready_o, 1'b1);
    cyc();
    rec_valid_i = 1'b0;
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [2:0] addr,
                          input logic [31:0] rbus, input logic [31:0] lbus);
    check_eq({tag, "_addr"}, tbl_addr_o, addr);
    check_eq({tag, "_wren"}, {tbl_wren_ref_addr_o, tbl_wren_lease_o, tbl_rmen_o}, 3'b110);
    check_eq({tag, "_refbus"}, tbl_ref_addr_o, rbus);
    check_eq({tag, "_leasebus"}, tbl_lease_o, lbus);
    check_eq({tag, "_busy"}, busy_o, 1'b1);
  endtask

  task automatic check_clr(input string tag, input logic [2:0] addr);
    check_eq({tag, "_addr"}, tbl_addr_o, addr);
    check_eq({tag, "_en"}, {tbl_wren_ref_addr_o, tbl_wren_lease_o, tbl_rmen_o}, 3'b001);
    check_eq({tag, "_bus"}, {tbl_ref_addr_o, tbl_lease_o}, 64'h0);
    check_eq({tag, "_busy"}, busy_o, 1'b1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    check_eq("rst_ready", rec_ready_o, 1'b0);
    check_eq("rst_en", {tbl_wren_ref_addr_o, tbl_wren_lease_o, tbl_rmen_o}, 3'b000);
    check_eq("rst_status", {busy_o, count_o, full_o, overflow_o, tbl_addr_o}, 9'h0);
    reset_i = 1'b0;
    #1;
    check_eq("post_rst_ready", rec_ready_o, 1'b1);

    // Single record: array 1 then array 0, busy exactly two cycles
    offer("one", 32'h1000, 32'h20, 32'h40, 9'h1FF);
    check_wr("one_t1", 3'd4, 32'h40, 32'h1FF);
    cyc();
    check_wr("one_t0", 3'd0, 32'h1000, 32'h20);
    cyc();
    check_eq("one_busy_end", busy_o, 1'b0);
    check_eq("one_count", count_o, 3'd1);
    check_eq("one_idle_addr", tbl_addr_o, 3'd1);
    check_eq("one_idle_bus", {tbl_ref_addr_o, tbl_lease_o}, 64'h0);

    // Reset during WR_T1 aborts the write
    offer("rstmid", 32'h6000, 32'h66, 32'h67, 9'h068);
    check_eq("rstmid_t1_addr", tbl_addr_o, 3'd5);
    reset_i = 1'b1;
    cyc();
    check_eq("rstmid_en", {tbl_wren_ref_addr_o, tbl_wren_lease_o, tbl_rmen_o}, 3'b000);
    check_eq("rstmid_count", count_o, 3'd0);
    check_eq("rstmid_busy", busy_o, 1'b0);
    reset_i = 1'b0;
    cyc();
    check_eq("rstmid_ready", rec_ready_o, 1'b1);
    check_eq("rstmid_addr", tbl_addr_o, 3'd0);

    // Four back-to-back records fill the table
    rec_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rec_ref_addr_i = 32'h2000 + k;
      rec_lease0_i   = 32'h100 + k;
      rec_lease1_i   = 32'h200 + k;
      rec_prob_i     = 9'(9'h10 + k);
      #1;
      check_eq($sformatf("fill%0d_ready", k), rec_ready_o, 1'b1);
      cyc();
      check_wr($sformatf("fill%0d_t1", k), 3'(4 + k), 32'h200 + k, 32'(9'h10 + k));
      check_eq($sformatf("fill%0d_t1_rdy", k), rec_ready_o, 1'b0);
      cyc();
      check_wr($sformatf("fill%0d_t0", k), 3'(k), 32'h2000 + k, 32'h100 + k);
      check_eq($sformatf("fill%0d_t0_rdy", k), rec_ready_o, 1'b0);
      cyc();
    end
    rec_valid_i = 1'b0;
    #1;
    check_eq("fill_count", count_o, 3'd4);
    check_eq("fill_full", full_o, 1'b1);
    check_eq("fill_ovf", overflow_o, 1'b0);

    // Fifth record dropped while full
    offer("drop", 32'hDEAD, 32'h1, 32'h2, 9'h3);
    check_eq("drop_busy", busy_o, 1'b0);
    check_eq("drop_en", {tbl_wren_ref_addr_o, tbl_wren_lease_o, tbl_rmen_o}, 3'b000);
    check_eq("drop_ovf", overflow_o, 1'b1);
    check_eq("drop_count", count_o, 3'd4);
    check_eq("drop_addr", tbl_addr_o, 3'd0);

    // Clear from IDLE sweeps addresses 0..3
    clear_i = 1'b1;
    #1;
    check_eq("clr_ready", rec_ready_o, 1'b0);
    cyc();
    clear_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_clr($sformatf("clr%0d", i), 3'(i));
      cyc();
    end
    check_eq("clr_done", {busy_o, count_o, full_o, overflow_o}, 6'h0);
    check_eq("clr_done_en", tbl_rmen_o, 1'b0);
    offer("after_clr", 32'h3000, 32'h30, 32'h50, 9'h0AB);
    check_wr("after_clr_t1", 3'd4, 32'h50, 32'hAB);
    cyc();
    check_wr("after_clr_t0", 3'd0, 32'h3000, 32'h30);
    cyc();
    check_eq("after_clr_count", count_o, 3'd1);

    // Clear pulsed during WR_T1: record completes, then sweep
    offer("clrwr", 32'h4000, 32'h44, 32'h66, 9'h001);
    check_wr("clrwr_t1", 3'd5, 32'h66, 32'h1);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1;
    check_wr("clrwr_t0", 3'd1, 32'h4000, 32'h44);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check_clr($sformatf("clrwr_sweep%0d", i), 3'(i));
      cyc();
    end
    check_eq("clrwr_count", count_o, 3'd0);
    check_eq("clrwr_busy", busy_o, 1'b0);

    // Clear and valid together: clear wins, record taken afterwards
    rec_ref_addr_i = 32'h5000;
    rec_lease0_i   = 32'h55;
    rec_lease1_i   = 32'h77;
    rec_prob_i     = 9'h1A5;
    rec_valid_i    = 1'b1;
    clear_i        = 1'b1;
    #1;
    check_eq("both_ready", rec_ready_o, 1'b0);
    cyc();
    clear_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("both_sweep%0d_rdy", i), rec_ready_o, 1'b0);
      check_clr($sformatf("both_sweep%0d", i), 3'(i));
      cyc();
    end
    check_eq("both_ready_after", rec_ready_o, 1'b1);
    check_eq("both_busy_after", busy_o, 1'b0);
    cyc();
    rec_valid_i = 1'b0;
    #1;
    check_wr("both_t1", 3'd4, 32'h77, 32'h1A5);
    cyc();
    check_wr("both_t0", 3'd0, 32'h5000, 32'h55);
    cyc();
    check_eq("both_count", count_o, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lease_table_loader.md
Name: lease_table_loader

Overview:
Sequences the writes that populate the dual-array lease lookup table in the fully-associative lease cache. It accepts one lease record per valid/ready handshake (ref addr, lease0, lease1, lease0 probability) and splits it into the table's two-array write protocol. It also owns the table write pointer, fill count and overflow status, and runs a full-table invalidate sweep on request.

Parameters:
N_ENTRIES, 128, entries per table array; power of two, >=2
BW_LEASE_REGISTER, 32, lease value width; must be >=9
BW_REF_ADDR, 32, reference address width
BW_ENTRIES (local), CLOG2(N_ENTRIES), entry index width

Ports:
clock_i  in  1  system clock; single clock domain
reset_i  in  1  synchronous, active-high reset
rec_valid_i  in  1  record offered
rec_ready_o  out  1  record accepted when valid & ready
rec_ref_addr_i  in  BW_REF_ADDR  reference address
rec_lease0_i  in  BW_LEASE_REGISTER  lease0 value
rec_lease1_i  in  BW_LEASE_REGISTER  lease1 value
rec_prob_i  in  9  lease0 probability
clear_i  in  1  single-cycle pulse: invalidate table, reset pointer
busy_o  out  1  high whenever FSM is not IDLE
count_o  out  BW_ENTRIES+1  entries written since last clear/reset
full_o  out  1  count_o == N_ENTRIES
overflow_o  out  1  sticky: a record was dropped while full
tbl_addr_o  out  BW_ENTRIES+1  table addr; MSB selects array (0: ref/lease0, 1: lease1/prob)
tbl_wren_ref_addr_o  out  1  table ref-addr-bus write enable
tbl_wren_lease_o  out  1  table lease-bus write enable
tbl_rmen_o  out  1  table invalidate enable
tbl_ref_addr_o  out  BW_REF_ADDR  table ref-addr data bus
tbl_lease_o  out  BW_LEASE_REGISTER  table lease data bus

Behaviour:
- Reset: FSM=IDLE; all outputs 0; pointer, count, overflow and pending-clear flag cleared; record regs 0.
- States: IDLE, WR_T1, WR_T0, CLEAR.
- IDLE: rec_ready_o = !clear_i & !clear_pending. On handshake, capture the record.
  - If !full: go to WR_T1.
  - If full: discard the record, set overflow_o, stay in IDLE, no table write. Upstream never stalls.
- WR_T1 (1 cycle): tbl_addr_o={1,ptr}; both wrens=1; tbl_ref_addr_o = lease1 zero-extended/truncated to BW_REF_ADDR; tbl_lease_o = prob zero-extended. Go to WR_T0.
- WR_T0 (1 cycle): tbl_addr_o={0,ptr}; both wrens=1; tbl_ref_addr_o=ref_addr; tbl_lease_o=lease0. This write sets the entry valid. At the cycle end ptr++ and count++. Go to IDLE, or to CLEAR if clear_pending.
- Array 1 is always written before array 0, so an entry never hits with stale lease1/prob.
- Throughput: 1 record per 3 cycles. Latency from handshake to valid entry: 2 cycles.
- ptr wraps 0..N_ENTRIES-1. It cannot wrap while entries are live, because full blocks writes.
- clear_i in IDLE enters CLEAR next cycle and has priority over a simultaneous rec_valid_i (ready is low). clear_i during WR_T1/WR_T0 sets clear_pending; the in-flight record completes first.
- CLEAR: N_ENTRIES cycles, index i=0..N-1. tbl_addr_o={0,i}, tbl_rmen_o=1, wrens=0, data buses 0. After the last index: ptr=0, count=0, overflow=0, clear_pending=0, go to IDLE.
- clear_i during CLEAR is ignored.
- Outside WR_T1/WR_T0/CLEAR: all tbl_* enables are 0, tbl_addr_o holds {0,ptr}, and data buses are 0.
- Reset asserted mid-write or mid-clear aborts immediately to the reset state. The table is reset by its own reset.

Decomposition:
- Shared package (lease cache pkg): FSM state encoding, PROB_W=9, CLOG2 macro, and the array-select bit positions for the table address MSB.
- No sub-module; the FSM, pointer/count and clear sweep fit in one module.

Test Plan:
- N_ENTRIES=4; one record (ref 0x1000, lease0 0x20, lease1 0x40, prob 0x1FF) -> cycle+1: addr=4, ref bus=0x40, lease bus=0x1FF; cycle+2: addr=0, ref bus=0x1000, lease bus=0x20; count_o=1, busy_o high for exactly 2 cycles.
- 4 back-to-back valid records -> ready pulses every 3 cycles; array-0 addrs 0,1,2,3 in order; full_o=1 after the 4th; a 5th record is accepted with no tbl write, and overflow_o=1.
- clear_i in IDLE after a fill -> busy_o for 4 cycles; rmen on addrs 0,1,2,3 with MSB 0; then count_o=0, full_o=0, overflow_o=0, next record writes addr 4 then 0.
- clear_i pulsed in WR_T1 -> record completes (WR_T0 write seen); CLEAR begins on the following cycle; count_o ends at 0.
- clear_i and rec_valid_i asserted together in IDLE -> rec_ready_o=0 that cycle; the record is accepted only after the clear completes.
- reset_i asserted during WR_T1 -> next cycle all tbl_* enables 0, count_o=0, FSM IDLE, rec_ready_o=1 the cycle after reset deasserts.
